// File: rtl/approx_mul_rr_scheduler.sv
// approx_mul_rr_scheduler: round-robin sharing of one 8x8 approximate/exact multiplier across N requesters
module approx_mul_rr_scheduler #(
    parameter int N    = 4,
    parameter int IDW  = $clog2(N),
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [8*N-1:0]    req_x,
    input  logic [8*N-1:0]    req_y,
    input  logic [N-1:0]      req_exact,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [15:0]       resp_z,
    output logic [IDW-1:0]    resp_id,
    output logic              resp_exact,
    output logic              busy,
    output logic [CNTW-1:0]   op_count
);
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            s1_v_q, s1_e_q;
    logic [7:0]      s1_x_q, s1_y_q;
    logic [IDW-1:0]  s1_id_q;
    logic            rv_q, re_q;
    logic [15:0]     rz_q;
    logic [IDW-1:0]  rid_q;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            adv, found, xfer;
    logic [IDW-1:0]  gnt;
    logic [IDW:0]    cand;
    logic [7:0]      p1, p2, p3, p4;
    logic [15:0]     prod;

    assign adv  = !(rv_q && !resp_ready);
    assign xfer = found && adv && rst_n;

    // Rotating-priority search: first valid requester at or after the pointer
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found = 1'b1;
                gnt   = cand[IDW-1:0];
            end
        end
        req_ready = xfer ? ({{(N-1){1'b0}}, 1'b1} << gnt) : '0;
        ptr_d     = !xfer ? ptr_q : (gnt == IDW'(N-1)) ? '0 : gnt + 1'b1;
    end

    // Product from stage-1 operands; low-part approximation keeps only the listed carry-ish bits
    always_comb begin
        p1   = s1_y_q & {8{s1_x_q[0]}};
        p2   = s1_y_q & {8{s1_x_q[1]}};
        p3   = s1_y_q & {8{s1_x_q[2]}};
        p4   = s1_y_q & {8{s1_x_q[3]}};
        prod = s1_e_q ? {8'b0, s1_y_q} * {8'b0, s1_x_q}
             : (({8'b0, s1_y_q} * {12'b0, s1_x_q[7:4]}) << 4)
             + {5'b0, p4[7], p3[6] & p4[5], p2[7], p1[6] | p2[5], 7'b0}
             + {6'b0, p3[7] & p4[6], p3[6] ^ p4[5], p1[7] | p2[6], 7'b0}
             + {6'b0, p3[7] | p4[6], p3[5] | p4[4], 8'b0};
        cnt_d = cnt_q + CNTW'(rv_q && resp_ready && !(&cnt_q));
    end

    // Round-robin pointer advances past the requester just served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    // Operand stage captures the granted request; a bubble is recorded when nothing transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q  <= 1'b0;
            s1_x_q  <= '0;
            s1_y_q  <= '0;
            s1_e_q  <= 1'b0;
            s1_id_q <= '0;
        end else if (adv) begin
            s1_v_q  <= xfer;
            s1_x_q  <= req_x[8*gnt +: 8];
            s1_y_q  <= req_y[8*gnt +: 8];
            s1_e_q  <= req_exact[gnt];
            s1_id_q <= gnt;
        end
    end

    // Product stage doubles as the response register and freezes while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_q  <= 1'b0;
            rz_q  <= '0;
            rid_q <= '0;
            re_q  <= 1'b0;
        end else if (adv) begin
            rv_q  <= s1_v_q;
            rz_q  <= prod;
            rid_q <= s1_id_q;
            re_q  <= s1_e_q;
        end
    end

    // Saturating count of accepted responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign resp_valid = rv_q;
    assign resp_z     = rz_q;
    assign resp_id    = rid_q;
    assign resp_exact = re_q;
    assign busy       = s1_v_q | rv_q;
    assign op_count   = cnt_q;
endmodule

// File: tb/tb_approx_mul_rr_scheduler.sv
// tb_approx_mul_rr_scheduler: scoreboard bench for the shared approximate multiplier scheduler
module tb_approx_mul_rr_scheduler;
    localparam int N = 4, IDW = 2, CNTW = 4;

    logic            clk = 1'b0, rst_n = 1'b1;
    logic [N-1:0]    req_valid = '0, req_ready, req_exact = '0;
    logic [8*N-1:0]  req_x = '0, req_y = '0;
    logic            resp_valid, resp_ready = 1'b1, resp_exact, busy;
    logic [15:0]     resp_z;
    logic [IDW-1:0]  resp_id;
    logic [CNTW-1:0] op_count;

    approx_mul_rr_scheduler #(.N(N), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_exact(req_exact),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_z(resp_z),
        .resp_id(resp_id), .resp_exact(resp_exact), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference multiplier written from the bit-level definition
    function automatic logic [15:0] ref_mul(logic [7:0] x, logic [7:0] y, logic e);
        logic [7:0]  p [1:4];
        logic [15:0] s;
        if (e) return 16'(x) * 16'(y);
        for (int k = 1; k <= 4; k++) p[k] = x[k-1] ? y : 8'h00;
        s = (16'(y) * 16'(x[7:4])) << 4;
        s = s + (16'(p[1][6] | p[2][5]) << 7) + (16'(p[2][7]) << 8)
              + (16'(p[3][6] & p[4][5]) << 9) + (16'(p[4][7]) << 10);
        s = s + (16'(p[1][7] | p[2][6]) << 7) + (16'(p[3][6] ^ p[4][5]) << 8)
              + (16'(p[3][7] & p[4][6]) << 9);
        s = s + (16'(p[3][5] | p[4][4]) << 8) + (16'(p[3][7] | p[4][6]) << 9);
        return s;
    endfunction

    // Per-requester stimulus storage: main writes wr, driver owns rd
    logic [16:0] mem [N][64];
    int wr [N], rd [N], hs_cnt [N], hs_seen [N];

    task automatic push_req(int i, logic [7:0] x, logic [7:0] y, logic e);
        mem[i][wr[i]] = {e, x, y};
        wr[i]++;
    endtask

    // Driver: each requester holds its item until accepted, then loads the next one
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                req_valid[i] = 1'b0;
                rd[i] = wr[i];
                hs_seen[i] = hs_cnt[i];
            end else begin
                if (hs_cnt[i] != hs_seen[i]) begin
                    hs_seen[i] = hs_cnt[i];
                    req_valid[i] = 1'b0;
                end
                if (!req_valid[i] && rd[i] < wr[i]) begin
                    {req_exact[i], req_x[8*i +: 8], req_y[8*i +: 8]} = mem[i][rd[i]];
                    rd[i]++;
                    req_valid[i] = 1'b1;
                end
            end
        end
    end

    // Monitor: cycle model of arbitration/valids plus response scoreboard
    logic [18:0]     sb [$];
    logic [15:0]     zlog [256];
    int              glog [256];
    int              zcount = 0, gcount = 0;
    logic            m_s1v = 1'b0, m_rv = 1'b0;
    logic [IDW-1:0]  m_ptr = '0;
    logic [CNTW-1:0] m_cnt = '0;

    always @(negedge clk) begin : mon
        logic           m_adv, m_found;
        logic [IDW-1:0] m_g;
        logic [N-1:0]   exp_rdy;
        logic [18:0]    e;
        if (!rst_n) begin
            m_s1v = 1'b0; m_rv = 1'b0; m_ptr = '0; m_cnt = '0;
            sb.delete();
        end else begin
            m_adv = !(m_rv && !resp_ready);
            m_found = 1'b0;
            m_g = '0;
            for (int k = 0; k < N; k++)
                if (!m_found && req_valid[(int'(m_ptr) + k) % N]) begin
                    m_found = 1'b1;
                    m_g = IDW'((int'(m_ptr) + k) % N);
                end
            exp_rdy = (m_found && m_adv) ? (4'b0001 << m_g) : 4'b0000;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("resp_valid", 32'(resp_valid), 32'(m_rv));
            check("busy", 32'(busy), 32'(m_s1v | m_rv));
            check("op_count", 32'(op_count), 32'(m_cnt));
            if (resp_valid) begin
                if (sb.size() == 0) check("resp_unexpected", 32'(resp_valid), 32'd0);
                else begin
                    e = sb[0];
                    check("resp_z", 32'(resp_z), 32'(e[15:0]));
                    check("resp_id", 32'(resp_id), 32'(e[17:16]));
                    check("resp_exact", 32'(resp_exact), 32'(e[18]));
                    if (resp_ready) begin
                        void'(sb.pop_front());
                        zlog[zcount] = resp_z;
                        zcount++;
                    end
                end
            end
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back({req_exact[i], 2'(i), ref_mul(req_x[8*i +: 8], req_y[8*i +: 8], req_exact[i])});
                    hs_cnt[i]++;
                    glog[gcount] = i;
                    gcount++;
                end
            if (m_rv && resp_ready && m_cnt != '1) m_cnt++;
            if (m_adv) begin
                m_rv = m_s1v;
                m_s1v = m_found;
                if (m_found) m_ptr = (m_g == IDW'(N-1)) ? '0 : m_g + 1'b1;
            end
        end
    end

    task automatic drain(string tag);
        bit done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk);
            #2;
            done = (req_valid == '0) && (sb.size() == 0) && !busy;
            for (int i = 0; i < N; i++) if (rd[i] != wr[i]) done = 1'b0;
        end
        check({tag, "_drain"}, 32'(done), 32'd1);
        #2;
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_op_count"}, 32'(op_count), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_resp_z"}, 32'(resp_z), 32'd0);
        check({tag, "_resp_id"}, 32'(resp_id), 32'd0);
        check({tag, "_resp_exact"}, 32'(resp_exact), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_vals("rst");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        int zb, gb, g0;
        logic [15:0] z0;
        #1 rst_n = 1'b0;
        #3 check_reset_vals("init");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        zb = zcount;
        push_req(0, 8'hFF, 8'hFF, 1'b0);
        push_req(0, 8'hFF, 8'hFF, 1'b1);
        push_req(0, 8'h0F, 8'hFF, 1'b0);
        push_req(0, 8'h0F, 8'hFF, 1'b1);
        push_req(0, 8'h10, 8'h0F, 1'b0);
        push_req(0, 8'h10, 8'h0F, 1'b1);
        drain("directed");
        check("z_ff_ff_apx", 32'(zlog[zb]), 32'h FC10);
        check("z_ff_ff_ex", 32'(zlog[zb+1]), 32'h FE01);
        check("z_0f_ff_apx", 32'(zlog[zb+2]), 32'h 0D00);
        check("z_0f_ff_ex", 32'(zlog[zb+3]), 32'h 0EF1);
        check("z_10_0f_apx", 32'(zlog[zb+4]), 32'h 00F0);
        check("z_10_0f_ex", 32'(zlog[zb+5]), 32'h 00F0);
        check("count_6", 32'(op_count), 32'd6);

        do_reset();
        gb = gcount;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < N; i++)
                push_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
        drain("fair");
        for (int k = 0; k < 16; k++) check("grant_order", 32'(glog[gb+k]), 32'(k % N));
        check("count_sat", 32'(op_count), 32'h F);

        gb = gcount;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < N; i++)
                push_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
        repeat (3) @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        #1;
        z0 = resp_z;
        g0 = gcount;
        check("bp_valid", 32'(resp_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            #1;
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_hold_z", 32'(resp_z), 32'(z0));
        end
        check("bp_no_grant", 32'(gcount), 32'(g0));
        @(posedge clk);
        #1 resp_ready = 1'b1;
        drain("bp");
        check("bp_total", 32'(gcount - gb), 32'd16);

        for (int r = 0; r < 6; r++) push_req(1, 8'($urandom), 8'($urandom), 1'($urandom));
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(resp_valid), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("mid");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        gb = gcount;
        push_req(2, 8'h12, 8'h34, 1'b0);
        push_req(0, 8'h56, 8'h78, 1'b1);
        drain("post_rst");
        check("first_grant", 32'(glog[gb]), 32'd0);
        check("second_grant", 32'(glog[gb+1]), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
